mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter and sequencer for the shared 4-to-1, 4-bit data mux. It takes one request line per mux input, grants the mux to one requester at a time, and allows bounded bursts per grant. It drives `sel` and captures the selected word into a one-deep valid/ready output register. It sits between the four producers feeding `a`..`d` and the single downstream consumer of `out`.

## Interface
- `DATA_W`, default 4: width of each data input and of `out_data`.
- `MAX_BURST`, default 4: maximum transfers per grant. Legal range 1..15.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-input request. Bit 0 = a, 1 = b, 2 = c, 3 = d. While high, the requester holds its data stable.
- `a`, `b`, `c`, `d`  in  DATA_W each  mux data inputs.
- `ack`  out  4  one-hot, combinational pulse. Marks the cycle the granted word is captured; the requester advances or drops `req` after it.
- `sel`  out  2  registered mux select, equal to the granted index.
- `busy`  out  1  high in GRANT state.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  DATA_W  captured word.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid && out_ready`.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `ack`=0, `sel`=0, `busy`=0. State = IDLE, `last`=3 (so `a` has first priority), burst count = 0.
- FSM states:
  - IDLE: if `|req`, pick the first set bit scanning `last+1, last+2, …` modulo 4. Register it into `sel`, clear the burst count, go to GRANT. Otherwise stay in IDLE.
  - GRANT:
    - `space = !out_valid || out_ready`.
    - Transfer when `req[sel] && space`: `ack[sel]`=1, `out_data` <= word at mux input `sel`, `out_valid` <= 1, count += 1.
    - Exit to IDLE with `last` <= `sel` when either:
      - `req[sel]`=0 in a cycle (no transfer that cycle), or
      - a transfer makes the count equal `MAX_BURST`.
  - The count is 4 bits wide and never wraps; the `MAX_BURST` ceiling prevents it.
- Output register:
  - Set by a transfer. Cleared on `out_ready` with no simultaneous transfer.
  - A simultaneous pop and transfer keeps `out_valid`=1 with the new word.
  - Back-pressure (`space`=0) stalls GRANT without ending the grant and without counting.
- `sel` changes only on the IDLE→GRANT edge. It holds its value through IDLE.
- `ack` is never asserted in IDLE, and never on a bit other than `sel`.
- Requests that arrive mid-grant wait for IDLE. No preemption.
- A requester that drops and re-raises within a grant loses the grant (exit on the drop).
- Reset mid-operation: all state returns to reset values immediately. Any word in the output register is discarded.

## Timing
- `req` rises at edge N in IDLE → `sel`/`busy` valid after edge N+1. First `ack` is in cycle N+1 if `space`. `out_valid` is set after edge N+2.
- Steady burst with `out_ready`=1: one transfer per cycle.
- Grant-to-grant gap: exactly one IDLE cycle.
- Fairness: a continuously requesting input waits at most 3 × (`MAX_BURST` + 1) + 1 cycles for its grant with no back-pressure.
- `ack` is combinational from `req`, `out_valid`, `out_ready` and state, in the same cycle. No combinational path from `req` to `sel`.

## Structure
- Package `mux_arb_pkg` holds:
  - state enum `arb_state_t` {IDLE, GRANT};
  - `N_REQ` = 4;
  - `SEL_W` = 2;
  - `CNT_W` = 4.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs `req[3:0]` and `last[1:0]`; outputs `found` and `idx[1:0]`.
- The data mux is instantiated inline as a `case` on `sel`.

## Test plan
- Reset then `req`=4'b0001, `a`=4'h5, `out_ready`=1, `req` dropped after the first `ack` → one `ack`=4'b0001, `out_data`=5 two cycles after `req`. `sel`=0, then IDLE.
- `req`=4'b1111 held, `MAX_BURST`=4, `out_ready`=1 → grants in the order a, b, c, d, a.
  - Each grant gives exactly 4 transfers, separated by one IDLE cycle.
  - `ack` bits follow `sel`.
- Back-pressure: `req`=4'b0100 held, `c` incrementing per `ack`, `out_ready`=0 for 5 cycles after the first capture.
  - `out_valid` stays 1 and `out_data` is held; no further `ack` while stalled.
  - Burst completes after release with the count unchanged by the stall.
- Simultaneous pop and capture: `out_valid`=1 and `out_ready`=1 in the same cycle as a transfer → `out_valid` stays 1 and `out_data` updates to the new word.
- After a grant to `b` ends, `req`=4'b0011 → next grant is `a` (scan starts at index 2 and wraps past 3 to 0).
- Assert `rst_n`=0 mid-burst with `out_valid`=1 → all outputs go to 0 immediately. After release, the first grant goes to the lowest set `req` bit.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and widths for the round-robin mux arbiter
package mux_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit after last (mod 4)
// ports: req (request lines), last (previous grant), found (any request), idx (chosen index)
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  // scan from the farthest offset down so the nearest requester after last wins
  always_comb begin
    found = |req;
    idx = last;
    for (int i = N_REQ; i >= 1; i--)
      if (req[last + SEL_W'(i)]) idx = last + SEL_W'(i);
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst arbiter driving a 4:1 mux into a one-deep valid/ready register
// ports: req/a..d from producers, ack one-hot capture pulse, sel registered grant,
//        busy while granted, out_valid/out_data/out_ready toward the consumer
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [N_REQ-1:0]  ack,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);
  arb_state_t        state, state_n;
  logic [SEL_W-1:0]  last, pick_idx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] word;
  logic              found, space, xfer, last_xfer;

  rr_pick u_pick (.req(req), .last(last), .found(found), .idx(pick_idx));

  always_comb begin
    word = a;
    case (sel)
      2'd0: word = a;
      2'd1: word = b;
      2'd2: word = c;
      2'd3: word = d;
    endcase
  end

  assign space     = !out_valid || out_ready;
  assign xfer      = state == GRANT && req[sel] && space;
  assign last_xfer = xfer && cnt + CNT_W'(1) == CNT_W'(MAX_BURST);
  assign ack       = xfer ? N_REQ'(1) << sel : '0;
  assign busy      = state == GRANT;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // a grant ends on a dropped request (no transfer that cycle) or on the final burst transfer
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = found ? GRANT : IDLE;
    else if (!req[sel] || last_xfer) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel  <= '0;
      last <= SEL_W'(N_REQ - 1);
      cnt  <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        sel <= pick_idx;
        cnt <= '0;
      end
    end else begin
      if (xfer) cnt <= cnt + CNT_W'(1);
      if (state_n == IDLE) last <= sel;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= word;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
  logic [3:0]  req = '0, a = '0, b = '0, c = '0, d = '0;
  logic [3:0]  ack, out_data;
  logic [1:0]  sel;
  logic        busy, out_valid;
  logic [11:0] obs;
  int          n_cmp = 0, n_bad = 0;

  mux_rr_arbiter #(.DATA_W(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .ack(ack), .sel(sel), .busy(busy), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // {busy, sel, ack, out_valid, out_data}; [11:5] is {busy, sel, ack}
  assign obs = {busy, sel, ack, out_valid, out_data};

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if (obs !== 12'h000) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs, 12'h000);
    end
  endtask

  task automatic test_single;
    cyc();
    req = 4'b0001; a = 4'h5; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (obs !== {1'b0, 2'd0, 4'b0000, 1'b0, 4'h0}) begin
      n_bad++; $display("FAIL single_idle: got %h", obs);
    end
    cyc(); #1;
    n_cmp++;
    if (obs !== {1'b1, 2'd0, 4'b0001, 1'b0, 4'h0}) begin
      n_bad++; $display("FAIL single_grant: got %h want %h", obs, {1'b1, 2'd0, 4'b0001, 1'b0, 4'h0});
    end
    cyc(); req = '0; #1;
    n_cmp++;
    if (obs !== {1'b1, 2'd0, 4'b0000, 1'b1, 4'h5}) begin
      n_bad++; $display("FAIL single_capture: got %h want %h", obs, {1'b1, 2'd0, 4'b0000, 1'b1, 4'h5});
    end
    cyc(); #1;
    n_cmp++;
    if (obs !== {1'b0, 2'd0, 4'b0000, 1'b0, 4'h5}) begin
      n_bad++; $display("FAIL single_idle_after: got %h want %h", obs, {1'b0, 2'd0, 4'b0000, 1'b0, 4'h5});
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4; out_ready = 1'b1;
    cyc(); req = 4'b1111; #1;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(); #1;
        n_cmp++;
        if (obs[11:5] !== {1'b1, 2'(g % 4), 4'(1 << (g % 4))}) begin
          n_bad++;
          $display("FAIL rr_burst g%0d k%0d: got %b want %b", g, k, obs[11:5], {1'b1, 2'(g % 4), 4'(1 << (g % 4))});
        end
      end
      cyc(); #1;
      n_cmp++;
      if (obs !== {1'b0, 2'(g % 4), 4'b0000, 1'b1, 4'(g % 4 + 1)}) begin
        n_bad++;
        $display("FAIL rr_gap g%0d: got %h want %h", g, obs, {1'b0, 2'(g % 4), 4'b0000, 1'b1, 4'(g % 4 + 1)});
      end
    end
    req = '0;
  endtask

  task automatic test_back_pressure;
    cyc(); req = 4'b0100; c = 4'h0; out_ready = 1'b1;
    cyc(); #1;
    n_cmp++;
    if (obs[11:5] !== {1'b1, 2'd2, 4'b0100}) begin
      n_bad++; $display("FAIL bp_first: got %b", obs[11:5]);
    end
    cyc(); c = 4'h1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      #1;
      n_cmp++;
      if (obs !== {1'b1, 2'd2, 4'b0000, 1'b1, 4'h0}) begin
        n_bad++; $display("FAIL bp_stall %0d: got %h want %h", i, obs, {1'b1, 2'd2, 4'b0000, 1'b1, 4'h0});
      end
    end
    cyc(); out_ready = 1'b1; #1;
    n_cmp++;
    if (obs !== {1'b1, 2'd2, 4'b0100, 1'b1, 4'h0}) begin
      n_bad++; $display("FAIL bp_release: got %h want %h", obs, {1'b1, 2'd2, 4'b0100, 1'b1, 4'h0});
    end
    cyc(); c = 4'h2; #1;
    n_cmp++;
    if (obs !== {1'b1, 2'd2, 4'b0100, 1'b1, 4'h1}) begin
      n_bad++; $display("FAIL bp_third: got %h want %h", obs, {1'b1, 2'd2, 4'b0100, 1'b1, 4'h1});
    end
    cyc(); c = 4'h3; #1;
    n_cmp++;
    if (obs !== {1'b1, 2'd2, 4'b0100, 1'b1, 4'h2}) begin
      n_bad++; $display("FAIL bp_fourth: got %h want %h", obs, {1'b1, 2'd2, 4'b0100, 1'b1, 4'h2});
    end
    cyc(); #1;
    n_cmp++;
    if (obs !== {1'b0, 2'd2, 4'b0000, 1'b1, 4'h3}) begin
      n_bad++; $display("FAIL bp_end: got %h want %h", obs, {1'b0, 2'd2, 4'b0000, 1'b1, 4'h3});
    end
    req = '0;
  endtask

  task automatic test_pop_capture;
    cyc(); req = 4'b0001; a = 4'h9; out_ready = 1'b1;
    cyc(); #1;
    n_cmp++;
    if (obs[11:5] !== {1'b1, 2'd0, 4'b0001}) begin
      n_bad++; $display("FAIL pc_grant: got %b", obs[11:5]);
    end
    cyc(); a = 4'hA; #1;
    n_cmp++;
    if (obs !== {1'b1, 2'd0, 4'b0001, 1'b1, 4'h9}) begin
      n_bad++; $display("FAIL pc_both: got %h want %h", obs, {1'b1, 2'd0, 4'b0001, 1'b1, 4'h9});
    end
    cyc(); #1;
    n_cmp++;
    if (obs !== {1'b1, 2'd0, 4'b0001, 1'b1, 4'hA}) begin
      n_bad++; $display("FAIL pc_update: got %h want %h", obs, {1'b1, 2'd0, 4'b0001, 1'b1, 4'hA});
    end
    cyc(); req = '0; #1;
    n_cmp++;
    if (obs !== {1'b1, 2'd0, 4'b0000, 1'b1, 4'hA}) begin
      n_bad++; $display("FAIL pc_drop: got %h want %h", obs, {1'b1, 2'd0, 4'b0000, 1'b1, 4'hA});
    end
    cyc(); #1;
    n_cmp++;
    if (obs !== {1'b0, 2'd0, 4'b0000, 1'b0, 4'hA}) begin
      n_bad++; $display("FAIL pc_idle: got %h want %h", obs, {1'b0, 2'd0, 4'b0000, 1'b0, 4'hA});
    end
  endtask

  task automatic test_wrap;
    req = 4'b0010;
    cyc(); #1;
    n_cmp++;
    if (obs[11:5] !== {1'b1, 2'd1, 4'b0010}) begin
      n_bad++; $display("FAIL wrap_b: got %b", obs[11:5]);
    end
    cyc(); req = '0; #1;
    n_cmp++;
    if (obs[11:5] !== {1'b1, 2'd1, 4'b0000}) begin
      n_bad++; $display("FAIL wrap_b_drop: got %b", obs[11:5]);
    end
    cyc(); req = 4'b0011; #1;
    n_cmp++;
    if (obs[11:5] !== {1'b0, 2'd1, 4'b0000}) begin
      n_bad++; $display("FAIL wrap_idle_hold: got %b", obs[11:5]);
    end
    cyc(); #1;
    n_cmp++;
    if (obs[11:5] !== {1'b1, 2'd0, 4'b0001}) begin
      n_bad++; $display("FAIL wrap_a: got %b want %b", obs[11:5], {1'b1, 2'd0, 4'b0001});
    end
    cyc(); req = '0;
    cyc(); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL wrap_end: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    req = 4'b1000; d = 4'h7; out_ready = 1'b1;
    cyc(); #1;
    n_cmp++;
    if (obs[11:5] !== {1'b1, 2'd3, 4'b1000}) begin
      n_bad++; $display("FAIL rm_grant: got %b", obs[11:5]);
    end
    cyc(); out_ready = 1'b0; #1;
    n_cmp++;
    if (obs !== {1'b1, 2'd3, 4'b0000, 1'b1, 4'h7}) begin
      n_bad++; $display("FAIL rm_held: got %h want %h", obs, {1'b1, 2'd3, 4'b0000, 1'b1, 4'h7});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 12'h000) begin
      n_bad++; $display("FAIL rm_async: got %h want %h", obs, 12'h000);
    end
    req = 4'b1010; out_ready = 1'b1;
    cyc();
    cyc(); rst_n = 1'b1;
    cyc(); #1;
    n_cmp++;
    if (obs[11:5] !== {1'b1, 2'd1, 4'b0010}) begin
      n_bad++; $display("FAIL rm_first_grant: got %b want %b", obs[11:5], {1'b1, 2'd1, 4'b0010});
    end
    req = '0;
    cyc();
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_pop_capture();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
